cmd_exec: RTL and testbench

//  Executes decoded 3-byte SPI frames (command, databyte1, databyte2) against the board RAM.

---
 rtl/snake_pkg.sv | 25 ++
 rtl/fill_seq.sv | 40 ++++
 rtl/cmd_exec.sv | 108 ++++++++++
 tb/tb_cmd_exec.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared board geometry, opcode set and frame layout for the SPI command executor.
package snake_pkg;
  localparam int GRID_W    = 32;
  localparam int GRID_H    = 24;
  localparam int AW        = 10;
  localparam int LAST_ADDR = GRID_W * GRID_H - 1;

  typedef logic [3:0] cell_t;

  typedef enum logic [3:0] {
    OP_NOP        = 4'h0,
    OP_WRITE_CELL = 4'h1,
    OP_FILL_ALL   = 4'h2,
    OP_SET_SCORE  = 4'h3,
    OP_FILL_ROW   = 4'h4
  } opcode_e;

  typedef struct packed {
    logic [7:0] command;
    logic [7:0] databyte1;
    logic [7:0] databyte2;
  } frame_t;

  typedef enum logic {S_IDLE, S_FILL} state_e;
endpackage

// File: rtl/fill_seq.sv
// Write-stream generator: emits `count` consecutive RAM writes from start_addr.
// A count of 1 doubles as the single-cell write path.
module fill_seq
  import snake_pkg::*;
(
  input  logic          clk,
  input  logic          resetB,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] count,
  input  cell_t         value,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [7:0]    wdata,
  output logic          done
);
  logic [AW-1:0] rem;

  // done marks the cycle carrying the final write of the stream
  assign done = we && (rem == '0);

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      rem   <= '0;
    end else if (start) begin
      we    <= 1'b1;
      waddr <= start_addr;
      wdata <= {4'h0, value};
      rem   <= count - AW'(1);
    end else if (we && rem != '0) begin
      waddr <= waddr + AW'(1);
      rem   <= rem - AW'(1);
    end else begin
      we    <= 1'b0;
    end
  end
endmodule

// File: rtl/cmd_exec.sv
// Executes decoded 3-byte SPI frames against the board RAM write port and
// owns the score register; one-entry pending buffer between SPI and execution.
module cmd_exec
  import snake_pkg::*;
(
  input  logic          clk,
  input  logic          resetB,
  input  logic          spi_done,
  input  logic [7:0]    command,
  input  logic [7:0]    databyte1,
  input  logic [7:0]    databyte2,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [7:0]    wdata,
  output logic [9:0]    score,
  output logic          busy,
  output logic          err_cmd,
  output logic          err_ovf
);
  state_e        state, state_nxt;
  frame_t        pend;
  logic          pend_valid;
  logic          consume, done;
  logic          fill_start, set_score, cmd_bad;
  logic [AW-1:0] fill_addr, fill_cnt;
  logic          x_ok, y_ok;

  // The buffer can be drained while idle or on the edge that ends a fill
  assign consume = pend_valid && (state == S_IDLE || done);
  assign x_ok    = pend.databyte1 < 8'(GRID_W);
  assign y_ok    = pend.databyte2 < 8'(GRID_H);
  assign busy    = pend_valid | (state == S_FILL) | we;

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fill_start = 1'b0;
    fill_addr  = '0;
    fill_cnt   = '0;
    set_score  = 1'b0;
    cmd_bad    = 1'b0;
    if (state == S_FILL && done) state_nxt = S_IDLE;
    if (consume) begin
      case (pend.command[7:4])
        OP_NOP: ;
        OP_WRITE_CELL: begin
          if (x_ok && y_ok) begin
            fill_start = 1'b1;
            fill_addr  = {pend.databyte2[4:0], pend.databyte1[4:0]};
            fill_cnt   = AW'(1);
          end else cmd_bad = 1'b1;
        end
        OP_FILL_ALL: begin
          fill_start = 1'b1;
          fill_cnt   = AW'(LAST_ADDR + 1);
          state_nxt  = S_FILL;
        end
        OP_SET_SCORE: set_score = 1'b1;
        OP_FILL_ROW: begin
          if (y_ok) begin
            fill_start = 1'b1;
            fill_addr  = {pend.databyte2[4:0], 5'b0};
            fill_cnt   = AW'(GRID_W);
            state_nxt  = S_FILL;
          end else cmd_bad = 1'b1;
        end
        default: cmd_bad = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      pend       <= '0;
      pend_valid <= 1'b0;
      score      <= '0;
      err_cmd    <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      if (spi_done && (!pend_valid || consume)) begin
        pend       <= '{command: command, databyte1: databyte1, databyte2: databyte2};
        pend_valid <= 1'b1;
      end else begin
        if (spi_done) err_ovf <= 1'b1;
        if (consume)  pend_valid <= 1'b0;
      end
      if (set_score) score   <= {pend.databyte1[1:0], pend.databyte2};
      if (cmd_bad)   err_cmd <= 1'b1;
    end
  end

  fill_seq u_fill (
    .clk        (clk),
    .resetB     (resetB),
    .start      (fill_start),
    .start_addr (fill_addr),
    .count      (fill_cnt),
    .value      (pend.command[3:0]),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .done       (done)
  );
endmodule

// File: tb/tb_cmd_exec.sv
// Self-checking bench for cmd_exec: directed scenarios plus randomized frames
// checked against a write-list model of the board command set.
module tb_cmd_exec;
  logic       clk = 1'b0, resetB = 1'b0, spi_done = 1'b0;
  logic [7:0] command = '0, databyte1 = '0, databyte2 = '0;
  logic       we, busy, err_cmd, err_ovf;
  logic [9:0] waddr, score;
  logic [7:0] wdata;

  int checks = 0, errors = 0, cyc = 0;
  int obs_a[$], obs_d[$], obs_c[$];
  int exp_a[$], exp_d[$];
  int exp_score;
  bit exp_err, addr_over = 1'b0;

  cmd_exec dut (
    .clk(clk), .resetB(resetB), .spi_done(spi_done), .command(command),
    .databyte1(databyte1), .databyte2(databyte2), .we(we), .waddr(waddr),
    .wdata(wdata), .score(score), .busy(busy), .err_cmd(err_cmd), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetB && we) begin
      obs_a.push_back(int'(waddr));
      obs_d.push_back(int'(wdata));
      obs_c.push_back(cyc);
      if (waddr > 10'd767) addr_over = 1'b1;
    end
  end

  task automatic drive(input logic [7:0] c, input logic [7:0] d1, input logic [7:0] d2);
    spi_done = 1'b1; command = c; databyte1 = d1; databyte2 = d2;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] d1, input logic [7:0] d2);
    @(negedge clk); drive(c, d1, d2);
    @(negedge clk); spi_done = 1'b0;
  endtask

  task automatic clear_q();
    obs_a.delete(); obs_d.delete(); obs_c.delete(); exp_a.delete(); exp_d.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (busy) begin errors++; $display("FAIL wait_idle timeout busy=%0b after %0d cycles", busy, n); end
  endtask

  task automatic test_reset();
    @(negedge clk); resetB = 1'b0; spi_done = 1'b0;
    #1;
    checks++;
    if ({we, waddr, wdata, score, busy, err_cmd, err_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_state got we=%0b waddr=%0d wdata=%0h score=%0h busy=%0b ec=%0b eo=%0b exp all 0",
               we, waddr, wdata, score, busy, err_cmd, err_ovf);
    end
    repeat (2) @(negedge clk);
    resetB = 1'b1;
    clear_q();
  endtask

  task automatic test_write_cell();
    int k;
    clear_q();
    @(negedge clk); k = cyc; drive(8'h13, 8'd5, 8'd2);
    @(negedge clk); spi_done = 1'b0;
    checks++;
    if (we !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wc_e0 got we=%0b busy=%0b exp we=0 busy=1", we, busy); end
    @(negedge clk);
    checks++;
    if (we !== 1'b1 || waddr !== 10'd69 || wdata !== 8'h03) begin
      errors++; $display("FAIL wc_write got we=%0b waddr=%0d wdata=%0h exp 1/69/03", we, waddr, wdata);
    end
    @(negedge clk);
    checks++;
    if (we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wc_after got we=%0b busy=%0b exp 0/0", we, busy); end
    checks++;
    if (obs_c.size() != 1 || obs_c[0] != k + 2) begin
      errors++; $display("FAIL wc_latency got writes=%0d cyc=%0d exp 1 at %0d", obs_c.size(), obs_c.size() ? obs_c[0] : -1, k + 2);
    end
  endtask

  task automatic test_score();
    clear_q();
    send(8'h31, 8'h02, 8'h2C);
    wait_idle(20);
    checks++;
    if (score !== 10'h22C || obs_a.size() != 0) begin
      errors++; $display("FAIL set_score got score=%0h writes=%0d exp 22c/0", score, obs_a.size());
    end
  endtask

  task automatic test_fill_all();
    bit bad = 1'b0;
    clear_q();
    send(8'h21, 8'h00, 8'h00);
    wait_idle(2000);
    checks++;
    if (obs_a.size() != 768) bad = 1'b1;
    else for (int i = 0; i < 768; i++)
      if (obs_a[i] != i || obs_d[i] != 1 || obs_c[i] != obs_c[0] + i) bad = 1'b1;
    if (bad) begin errors++; $display("FAIL fill_all got writes=%0d exp 768 gap-free 0..767 data 01", obs_a.size()); end
    checks++;
    if (addr_over) begin errors++; $display("FAIL waddr_range got waddr>767 exp <=767"); end
  endtask

  task automatic test_fill_row();
    bit bad = 1'b0;
    clear_q();
    send(8'h42, 8'h00, 8'd23);
    wait_idle(100);
    checks++;
    if (obs_a.size() != 32) bad = 1'b1;
    else for (int i = 0; i < 32; i++)
      if (obs_a[i] != 736 + i || obs_d[i] != 2 || obs_c[i] != obs_c[0] + i) bad = 1'b1;
    if (bad) begin errors++; $display("FAIL fill_row23 got writes=%0d exp 32 gap-free 736..767 data 02", obs_a.size()); end
    checks++;
    if (err_cmd !== 1'b0) begin errors++; $display("FAIL fill_row_noerr got err_cmd=%0b exp 0", err_cmd); end
    clear_q();
    send(8'h42, 8'h00, 8'd24);
    wait_idle(20);
    checks++;
    if (err_cmd !== 1'b1 || obs_a.size() != 0) begin
      errors++; $display("FAIL fill_row24 got err_cmd=%0b writes=%0d exp 1/0", err_cmd, obs_a.size());
    end
  endtask

  task automatic test_overflow();
    bit bad = 1'b0;
    clear_q();
    send(8'h21, 8'h00, 8'h00);
    repeat (10) @(negedge clk);
    drive(8'h15, 8'd1, 8'd1);
    @(negedge clk); drive(8'h17, 8'd2, 8'd2);
    @(negedge clk); spi_done = 1'b0;
    checks++;
    if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got err_ovf=%0b exp 1", err_ovf); end
    wait_idle(2000);
    checks++;
    if (obs_a.size() != 769) bad = 1'b1;
    else if (obs_a[768] != 33 || obs_d[768] != 5 || obs_c[768] != obs_c[767] + 1 || obs_a[767] != 767) bad = 1'b1;
    if (bad) begin errors++; $display("FAIL ovf_stream got writes=%0d exp 769 ending addr 33 data 05 right after fill", obs_a.size()); end
  endtask

  task automatic test_illegal();
    clear_q();
    send(8'h90, 8'h00, 8'h00);
    wait_idle(20);
    checks++;
    if (err_cmd !== 1'b1 || err_ovf !== 1'b0 || obs_a.size() != 0) begin
      errors++; $display("FAIL illegal_op got ec=%0b eo=%0b writes=%0d exp 1/0/0", err_cmd, err_ovf, obs_a.size());
    end
  endtask

  task automatic test_back_to_back();
    int k;
    bit bad = 1'b0;
    clear_q();
    @(negedge clk); k = cyc;
    for (int i = 0; i < 4; i++) begin
      drive({4'h1, 4'(i + 6)}, 8'(i * 3), 8'(i + 10));
      exp_a.push_back((i + 10) * 32 + i * 3);
      exp_d.push_back(i + 6);
      @(negedge clk);
    end
    spi_done = 1'b0;
    wait_idle(20);
    checks++;
    if (obs_a.size() != 4) bad = 1'b1;
    else for (int i = 0; i < 4; i++)
      if (obs_a[i] != exp_a[i] || obs_d[i] != exp_d[i] || obs_c[i] != k + 2 + i) bad = 1'b1;
    if (bad) begin errors++; $display("FAIL back_to_back got writes=%0d exp 4 consecutive from cyc %0d", obs_a.size(), k + 2); end
  endtask

  // Runs after test_illegal: score still 0 from reset, err_cmd already set
  task automatic test_random();
    logic [7:0] fc[4], f1[4], f2[4];
    int n, kind, x, y, v;
    bit bad;
    exp_score = 0; exp_err = 1'b1;
    for (int g = 0; g < 40; g++) begin
      clear_q();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        kind = $urandom_range(0, 5);
        v = $urandom_range(0, 15);
        f1[i] = 8'($urandom); f2[i] = 8'($urandom);
        case (kind)
          0, 5: begin
            x = (kind == 5) ? $urandom_range(0, 31) : $urandom_range(0, 39);
            y = (kind == 5) ? $urandom_range(0, 23) : $urandom_range(0, 29);
            fc[i] = {4'h1, 4'(v)}; f1[i] = 8'(x); f2[i] = 8'(y);
            if (x < 32 && y < 24) begin exp_a.push_back(y * 32 + x); exp_d.push_back(v); end
            else exp_err = 1'b1;
          end
          1: begin fc[i] = {4'h3, 4'(v)}; exp_score = (int'(f1[i]) % 4) * 256 + int'(f2[i]); end
          2: begin
            y = $urandom_range(0, 27);
            fc[i] = {4'h4, 4'(v)}; f2[i] = 8'(y);
            if (y < 24) for (int j = 0; j < 32; j++) begin exp_a.push_back(y * 32 + j); exp_d.push_back(v); end
            else exp_err = 1'b1;
            n = i + 1;
          end
          3: fc[i] = {4'h0, 4'(v)};
          default: begin fc[i] = {4'($urandom_range(5, 15)), 4'(v)}; exp_err = 1'b1; end
        endcase
      end
      for (int i = 0; i < n; i++) begin @(negedge clk); drive(fc[i], f1[i], f2[i]); end
      @(negedge clk); spi_done = 1'b0;
      wait_idle(200);
      bad = (obs_a.size() != exp_a.size());
      if (!bad) for (int i = 0; i < obs_a.size(); i++)
        if (obs_a[i] != exp_a[i] || obs_d[i] != exp_d[i]) bad = 1'b1;
      checks++;
      if (bad) begin errors++; $display("FAIL rand_writes grp %0d got %0d writes exp %0d", g, obs_a.size(), exp_a.size()); end
      checks++;
      if (score !== 10'(exp_score) || err_cmd !== exp_err || err_ovf !== 1'b0) begin
        errors++; $display("FAIL rand_state grp %0d got score=%0h ec=%0b eo=%0b exp %0h/%0b/0", g, score, err_cmd, err_ovf, exp_score, exp_err);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    send(8'h2A, 8'h00, 8'h00);
    repeat (50) @(negedge clk);
    send(8'h31, 8'h03, 8'hFF);
    repeat (50) @(negedge clk);
    #2 resetB = 1'b0;
    #1;
    checks++;
    if ({we, waddr, wdata, score, busy, err_cmd, err_ovf} !== '0) begin
      errors++; $display("FAIL reset_mid_fill got we=%0b waddr=%0d wdata=%0h score=%0h busy=%0b exp all 0", we, waddr, wdata, score, busy);
    end
    clear_q();
    repeat (2) @(negedge clk);
    resetB = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (obs_a.size() != 0 || busy !== 1'b0 || score !== 10'h0) begin
      errors++; $display("FAIL post_reset got writes=%0d busy=%0b score=%0h exp 0/0/0", obs_a.size(), busy, score);
    end
  endtask

  initial begin
    test_reset();
    test_write_cell();
    test_score();
    test_fill_all();
    test_fill_row();
    test_overflow();
    test_reset();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
